// File: rtl/except_commit_unit.sv
// Exception commit stage sitting between MEM and WB.
// Registers the winning (lowest-index) cause of the accumulated exception
// vector together with EPC, BadVAddr and the delay-slot flag. The result is
// held for CP0 until it is acknowledged. A one-cycle blackout follows each
// acknowledge so that the redirect flush cannot post a second exception.
module except_commit_unit #(
    parameter int VEC_W = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16,
    parameter int IDX_W = $clog2(VEC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [VEC_W-1:0] vector_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  badvaddr_i,
    input  logic             bd_i,
    input  logic             ack_i,
    output logic             excp_valid_o,
    output logic [IDX_W-1:0] excp_idx_o,
    output logic [VEC_W-1:0] excp_onehot_o,
    output logic [PC_W-1:0]  epc_o,
    output logic [PC_W-1:0]  badvaddr_o,
    output logic             bd_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] win_idx;
    logic [VEC_W-1:0] win_onehot;
    logic [PC_W-1:0]  epc_next;
    logic             capture;

    // Priority encoder: bit 0 wins, so scan downwards and let the lowest set bit overwrite.
    always_comb begin
        win_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vector_i[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Isolate the lowest set bit directly for the one-hot output.
    assign win_onehot = vector_i & (~vector_i + VEC_W'(1));

    // A delay-slot instruction reports the branch PC; subtraction wraps modulo 2^PC_W.
    assign epc_next = bd_i ? (pc_i - PC_W'(4)) : pc_i;

    // Only a live, non-stalled, non-squashed instruction carrying a cause is committed.
    assign capture = valid_i & ~stall_i & ~flush_i & (|vector_i);

    // Commit FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            excp_valid_o  <= 1'b0;
            busy_o        <= 1'b0;
            excp_idx_o    <= '0;
            excp_onehot_o <= '0;
            epc_o         <= '0;
            badvaddr_o    <= '0;
            bd_o          <= 1'b0;
            count_o       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        state_reg     <= PEND;
                        excp_valid_o  <= 1'b1;
                        busy_o        <= 1'b1;
                        excp_idx_o    <= win_idx;
                        excp_onehot_o <= win_onehot;
                        epc_o         <= epc_next;
                        badvaddr_o    <= badvaddr_i;
                        bd_o          <= bd_i;
                    end
                end
                PEND: begin
                    // Inputs other than ack are ignored; the exception is already committed.
                    if (ack_i) begin
                        state_reg    <= BLANK;
                        excp_valid_o <= 1'b0;
                        busy_o       <= 1'b1;
                        if (count_o != {CNT_W{1'b1}}) begin
                            count_o <= count_o + CNT_W'(1);
                        end
                    end
                end
                BLANK: begin
                    state_reg    <= IDLE;
                    excp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    excp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_except_commit_unit.sv
// Bench for except_commit_unit: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the commit rules.
module tb_except_commit_unit;

    localparam int VEC_W = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 2;
    localparam int IDX_W = $clog2(VEC_W);

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i, stall_i, flush_i, bd_i, ack_i;
    logic [VEC_W-1:0] vector_i;
    logic [PC_W-1:0]  pc_i, badvaddr_i;
    logic             excp_valid_o, bd_o, busy_o;
    logic [IDX_W-1:0] excp_idx_o;
    logic [VEC_W-1:0] excp_onehot_o;
    logic [PC_W-1:0]  epc_o, badvaddr_o;
    logic [CNT_W-1:0] count_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of what CP0 should see.
    bit          m_posted;
    bit          m_blackout;
    int          m_idx;
    logic [31:0] m_onehot, m_epc, m_bad;
    bit          m_bd;
    int          m_count;

    except_commit_unit #(.VEC_W(VEC_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .vector_i(vector_i), .pc_i(pc_i), .badvaddr_i(badvaddr_i), .bd_i(bd_i), .ack_i(ack_i),
        .excp_valid_o(excp_valid_o), .excp_idx_o(excp_idx_o), .excp_onehot_o(excp_onehot_o),
        .epc_o(epc_o), .badvaddr_o(badvaddr_o), .bd_o(bd_o), .busy_o(busy_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_posted = 0; m_blackout = 0; m_idx = 0; m_onehot = 0;
        m_epc = 0; m_bad = 0; m_bd = 0; m_count = 0;
    endtask

    // One rising edge worth of commit rules, from the inputs the DUT just sampled.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_posted) begin
            if (ack_i) begin
                m_posted = 0;
                m_blackout = 1;
                if (m_count < (1 << CNT_W) - 1) m_count++;
            end
        end else if (m_blackout) begin
            m_blackout = 0;
        end else if (valid_i && !stall_i && !flush_i && vector_i != 0) begin
            for (int i = 0; i < VEC_W; i++) begin
                if (vector_i[i]) begin
                    m_idx = i;
                    break;
                end
            end
            m_onehot = 32'd1 << m_idx;
            m_epc    = bd_i ? pc_i - 32'd4 : pc_i;
            m_bad    = badvaddr_i;
            m_bd     = bd_i;
            m_posted = 1;
        end
    endtask

    task automatic compare_all();
        chk("valid", excp_valid_o, m_posted);
        chk("busy", busy_o, m_posted || m_blackout);
        chk("idx", excp_idx_o, m_idx);
        chk("onehot", excp_onehot_o, m_onehot);
        chk("epc", epc_o, m_epc);
        chk("badvaddr", badvaddr_o, m_bad);
        chk("bd", bd_o, m_bd);
        chk("count", count_o, m_count);
    endtask

    task automatic drive(input bit v, input bit st, input bit fl, input logic [31:0] vec,
                         input logic [31:0] pc, input logic [31:0] bad, input bit bd, input bit ack);
        valid_i = v; stall_i = st; flush_i = fl; vector_i = vec;
        pc_i = pc; badvaddr_i = bad; bd_i = bd; ack_i = ack;
    endtask

    // Advance one clock, update the model on the edge, check on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask

    // Post an exception, hold one cycle, acknowledge, let blackout pass.
    task automatic post_and_ack(input logic [31:0] vec, input logic [31:0] pc, input bit bd,
                                input int exp_count, input string tag);
        drive(1, 0, 0, vec, pc, 32'hDEAD_0000 ^ pc, bd, 0);
        cycle();
        chk({tag, "_posted"}, excp_valid_o, 1'b1);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        cycle();
        chk({tag, "_count"}, count_o, exp_count);
        idle_inputs();
        cycle();
    endtask

    initial begin
        logic [31:0] rv;
        model_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Zero vector never posts.
        drive(1, 0, 0, 32'h0, 32'h1234, 32'h0, 0, 0);
        repeat (3) cycle();
        chk("zero_vec_no_post", excp_valid_o, 1'b0);

        // Priority and posting.
        drive(1, 0, 0, 32'h8000_0120, 32'hBFC0_0100, 32'h0000_0BAD, 0, 0);
        cycle();
        chk("prio_valid", excp_valid_o, 1'b1);
        chk("prio_idx", excp_idx_o, 5);
        chk("prio_onehot", excp_onehot_o, 32'h20);
        chk("prio_epc", epc_o, 32'hBFC0_0100);
        chk("prio_busy", busy_o, 1'b1);

        // Hold: new vector and flush in PEND change nothing.
        drive(1, 0, 1, 32'h0000_0001, 32'h0000_2000, 32'h5555, 1, 0);
        cycle();
        drive(1, 0, 0, 32'h0000_0002, 32'h0000_3000, 32'h6666, 1, 0);
        cycle();
        chk("hold_idx", excp_idx_o, 5);
        chk("hold_epc", epc_o, 32'hBFC0_0100);

        // Acknowledge with a new exception presented: blackout, then capture.
        drive(1, 0, 0, 32'h0000_0004, 32'h0000_1004, 32'h0000_7777, 1, 1);
        cycle();
        chk("blank_valid", excp_valid_o, 1'b0);
        chk("blank_busy", busy_o, 1'b1);
        chk("ack1_count", count_o, 1);
        ack_i = 1'b0;
        cycle();
        chk("post_blank_valid", excp_valid_o, 1'b0);
        chk("post_blank_busy", busy_o, 1'b0);
        cycle();
        chk("ds_valid", excp_valid_o, 1'b1);
        chk("ds_idx", excp_idx_o, 2);
        chk("ds_epc", epc_o, 32'h0000_1000);
        chk("ds_bd", bd_o, 1'b1);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        cycle();
        chk("ack2_count", count_o, 2);
        idle_inputs();
        cycle();

        // Delay slot wrap at PC 0, then saturation.
        drive(1, 0, 0, 32'h0000_0100, 32'h0000_0000, 32'h0, 1, 0);
        cycle();
        chk("wrap_epc", epc_o, 32'hFFFF_FFFC);
        ack_i = 1'b1; valid_i = 1'b0;
        cycle();
        chk("ack3_count", count_o, 3);
        idle_inputs();
        cycle();
        post_and_ack(32'h0000_0040, 32'h0000_4000, 0, 3, "sat4");
        post_and_ack(32'h8000_0000, 32'h0000_5000, 0, 3, "sat5");
        chk("msb_idx", excp_idx_o, 31);

        // Stray ack in IDLE.
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        repeat (2) cycle();
        chk("stray_ack_count", count_o, 3);

        // Stall together with flush: no capture.
        drive(1, 1, 1, 32'h0000_0008, 32'h100, 32'h0, 0, 0);
        repeat (2) cycle();
        chk("stall_flush_no_post", excp_valid_o, 1'b0);

        // Reset mid-PEND clears everything immediately.
        drive(1, 0, 0, 32'h0000_0010, 32'h0000_8000, 32'h0000_9999, 1, 0);
        cycle();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", excp_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_bad", badvaddr_o, 32'h0);
        chk("rst_idx", excp_idx_o, 0);
        chk("rst_onehot", excp_onehot_o, 32'h0);
        chk("rst_count", count_o, 0);
        chk("rst_bd", bd_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        drive(1, 0, 0, 32'h0000_0300, 32'h0000_A000, 32'h0000_0042, 0, 0);
        cycle();
        chk("after_rst_valid", excp_valid_o, 1'b1);
        chk("after_rst_idx", excp_idx_o, 8);
        chk("after_rst_bad", badvaddr_o, 32'h0000_0042);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(3))
                0: rv = 32'h0;
                1: rv = 32'd1 << $urandom_range(31);
                default: rv = $urandom;
            endcase
            drive($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(6) == 0, rv,
                  ($urandom_range(7) == 0) ? 32'h0 : $urandom, $urandom,
                  $urandom_range(1) == 1, $urandom_range(9) < 4);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
